nibble_cmp_seq: RTL
===================

Name: nibble_cmp_seq

Overview:
- Sequential magnitude comparator for wide unsigned operands.
- Shares a single 4-bit nibble comparator across all nibbles, one nibble per clock, MSB nibble first.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area versus a full-width combinational compare.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range ≥ 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  W  operand A, unsigned.
- b  input  W  operand B, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- lt  output  1  A < B.
- eq  output  1  A == B.
- gt  output  1  A > B.
- busy  output  1  high in CMP or DONE.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, lt=eq=gt=0, busy=0, index=0, operand registers=0. in_ready=1 while rst is deasserted in IDLE.
- States:
  - IDLE: in_ready=1. When in_valid&&in_ready at an edge: latch a and b, set index=NIBBLES-1, clear lt/eq/gt and the decided flag, go to CMP.
  - CMP: compare A[4*index+3:4*index] against the same nibble of B.
    - First unequal nibble: latch lt or gt and set decided. Later nibbles never overwrite a decided result.
    - Leave for DONE when index==0, or on a decided nibble if early exit is enabled. Otherwise decrement index.
    - On leaving with decided still clear: set eq=1.
  - DONE: out_valid=1, results held stable. When out_valid&&out_ready at an edge: go to IDLE, drop out_valid. lt/eq/gt keep their value until the next accept.
- in_ready is combinational, equal to (state==IDLE). There is no overlap between operations; in_valid in CMP or DONE is ignored.
- Inputs a and b are don't-care after acceptance; only the latched copies are used.
- When out_valid=1, exactly one of lt/eq/gt is high.
- Latency, counted in edges from the accept edge to the first cycle with out_valid=1:
  - NIBBLES+1 in the worst case.
  - With early exit, (NIBBLES-p)+1, where p is the index of the first unequal nibble counted from the MSB side (p=NIBBLES-1 is the MSB nibble).
- out_ready held low: remain in DONE indefinitely.
- rst asserted in any state: immediately return to IDLE and discard the operation; no result is produced.
- NIBBLES=1: exactly one CMP cycle.

Optional Feature:
- Macro: NIBBLE_CMP_EARLY_EXIT_EN.
- Defined: CMP exits on the first unequal nibble; latency is data-dependent.
- Undefined: CMP always runs all NIBBLES cycles; latency is fixed at NIBBLES+1, giving constant-time compare. Results are identical in both builds.

Decomposition:
- Package nibble_cmp_pkg:
  - NIBBLE_W=4.
  - State typedef {IDLE, CMP, DONE}, 2-bit encoding.
  - Result one-hot constants RES_LT, RES_EQ, RES_GT.
- Sub-module: instantiate the existing comparator_4 as the shared nibble comparator.
  - Its Y0/Y1/Y2 outputs feed the lt/eq/gt decision.
  - The index mux on the operand registers sits in nibble_cmp_seq.

Test Plan:
- Reset mid-operation: accept a=16'h1234, b=16'h1235, pulse rst during the 2nd CMP cycle -> out_valid=0, lt=eq=gt=0, in_ready=1 after release, no result emitted.
- LSB difference: a=16'h1234, b=16'h1235 -> lt=1 with out_valid 5 edges after accept, in both builds.
- MSB difference: a=16'h8000, b=16'h7FFF -> gt=1.
  - With NIBBLE_CMP_EARLY_EXIT_EN: out_valid 2 edges after accept.
  - Without the macro: 5 edges after accept.
- Equal operands: a=b=16'hABCD -> eq=1, lt=gt=0, 5 edges after accept.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid, drive in_valid=1 with a new pair -> out_valid and result stable, in_ready=0, new pair not taken. Then raise out_ready -> IDLE, and the next pair is accepted the following cycle.
- Parameter corner: NIBBLES=1, a=4'h3, b=4'h3 -> eq=1 at 2 edges. Then a=4'h2, b=4'h3 -> lt=1 at 2 edges.

Source files
------------

// File: rtl/nibble_cmp_seq_pkg.sv
// Shared types and constants for the sequential nibble comparator.
// Optional build macro used by nibble_cmp_seq: NIBBLE_CMP_EARLY_EXIT_EN.
package nibble_cmp_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot result encoding, bit order {gt, eq, lt}
  localparam logic [2:0] RES_LT = 3'b001;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_GT = 3'b100;

endpackage

// File: rtl/nibble_cmp_seq_comparator_4.sv
// Existing 4-bit magnitude comparator, shared by every nibble step.
// Y0: A < B, Y1: A == B, Y2: A > B.
module comparator_4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       Y0,
  output logic       Y1,
  output logic       Y2
);

  assign Y0 = (A < B);
  assign Y1 = (A == B);
  assign Y2 = (A > B);

endmodule

// File: rtl/nibble_cmp_seq.sv
// Sequential unsigned magnitude comparator, one nibble per clock, MSB first.
// Build option: define NIBBLE_CMP_EARLY_EXIT_EN to stop on the first unequal
// nibble; otherwise every compare takes a fixed NIBBLES cycles.
module nibble_cmp_seq
  import nibble_cmp_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      lt,
  output logic                      eq,
  output logic                      gt,
  output logic                      busy
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t                             state, state_nx;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_q, b_q;
  logic [IDX_W-1:0]                   index, index_nx;
  logic [2:0]                         res, res_nx;
  logic                               decided, decided_nx;
  logic                               load;
  logic                               hit;
  logic                               leave;
  logic [NIBBLE_W-1:0]                nib_a, nib_b;
  logic                               y0, y1, y2;

  // Select the nibble pair addressed by index from the latched operands
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (index == IDX_W'(i)) begin
        nib_a = a_q[i];
        nib_b = b_q[i];
      end
    end
  end

  comparator_4 u_cmp (
    .A  (nib_a),
    .B  (nib_b),
    .Y0 (y0),
    .Y1 (y1),
    .Y2 (y2)
  );

  // Next-state, index walk and result decision
  always_comb begin
    state_nx   = state;
    index_nx   = index;
    res_nx     = res;
    decided_nx = decided;
    load       = 1'b0;
    hit        = 1'b0;
    leave      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          index_nx   = IDX_W'(NIBBLES - 1);
          res_nx     = '0;
          decided_nx = 1'b0;
          state_nx   = CMP;
        end
      end
      CMP: begin
        hit = !decided && !y1;
        if (hit) begin
          decided_nx = 1'b1;
          res_nx     = {y2, 1'b0, y0};
        end
        leave = (index == '0);
`ifdef NIBBLE_CMP_EARLY_EXIT_EN
        leave = leave || hit;
`endif
        if (leave) begin
          state_nx = DONE;
          if (!decided && !hit) begin
            res_nx = RES_EQ;
          end
        end else begin
          index_nx = index - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      index   <= '0;
      res     <= '0;
      decided <= 1'b0;
    end else begin
      state   <= state_nx;
      index   <= index_nx;
      res     <= res_nx;
      decided <= decided_nx;
    end
  end

  // Operand capture on accept; inputs are ignored afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign lt        = res[0];
  assign eq        = res[1];
  assign gt        = res[2];

endmodule
